// File: rtl/seq_detect_prog.sv
// -----------------------------------------------------------------------------
// seq_detect_prog
//   Programmable serial pattern detector with a Mealy (zero-latency) match
//   output and a saturating match counter.
//
//   The active pattern, length and overlap mode load at run time. A history
//   shift register holds previously accepted bits. The incoming bit is
//   appended to that history to form the candidate, and the low `len` bits
//   of the candidate are compared against the pattern. Bit [len-1] of the
//   pattern is the first bit received and bit [0] is the last.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-low reset
//   in_seq       in   serial data bit
//   in_valid     in   in_seq is sampled this cycle
//   cfg_load     in   one-cycle pulse; latches cfg_* and restarts the stream
//   cfg_pattern  in   [PAT_W-1:0] pattern
//   cfg_len      in   [LEN_W-1:0] pattern length (legal 2..PAT_W)
//   cfg_overlap  in   1 = overlapping detection
//   det_out      out  combinational match indication for the current bit
//   match_cnt    out  [CNT_W-1:0] saturating match count
//   cfg_err      out  active configuration is illegal (registered)
// -----------------------------------------------------------------------------
module seq_detect_prog #(
  parameter int               PAT_W   = 8,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(8'b0001_0110),
  parameter int               DEF_LEN = 5,
  parameter bit               DEF_OVL = 1'b0,
  localparam int              LEN_W   = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_seq,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  output logic             det_out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err
);

  localparam logic [LEN_W-1:0] DEF_LEN_V = LEN_W'(DEF_LEN);
  localparam logic [LEN_W-1:0] FILL_MAX  = LEN_W'(PAT_W);

  // A length is usable only if it names at least two bits and fits in history.
  function automatic logic len_illegal(input logic [LEN_W-1:0] len);
    return (int'(len) < 2) || (int'(len) > PAT_W);
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Fill increment that sticks at PAT_W; beyond that the history is full.
  function automatic logic [LEN_W-1:0] sat_inc_fill(input logic [LEN_W-1:0] v);
    return (v == FILL_MAX) ? v : v + 1'b1;
  endfunction

  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic             r_ovl;
  logic             r_err;
  logic [PAT_W-1:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic [CNT_W-1:0] r_cnt;

  logic [PAT_W:0]   w_cand;
  logic [PAT_W:0]   w_mask;
  logic             w_eq;
  logic             w_fill_ok;
  logic             w_acc;
  logic             w_match;

  // Candidate = history with the current bit appended as the newest (LSB).
  assign w_cand = {r_hist, in_seq};

  // Only the low `len` bits take part in the compare.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i <= PAT_W; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
  end

  assign w_eq      = ((w_cand ^ {1'b0, r_pat}) & w_mask) == '0;
  // Enough bits seen, counting the one arriving now.
  assign w_fill_ok = ({1'b0, r_fill} + 1'b1) >= {1'b0, r_len};
  // A config load takes priority; a bit arriving with it is dropped.
  assign w_acc     = in_valid & ~cfg_load;
  assign w_match   = w_acc & ~r_err & w_fill_ok & w_eq;

  // Gating with rst keeps the Mealy output quiet throughout reset.
  assign det_out   = w_match & rst;
  assign match_cnt = r_cnt;
  assign cfg_err   = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pat  <= DEF_PAT;
      r_len  <= DEF_LEN_V;
      r_ovl  <= DEF_OVL;
      r_err  <= len_illegal(DEF_LEN_V);
      r_hist <= '0;
      r_fill <= '0;
      r_cnt  <= '0;
    end else if (cfg_load) begin
      r_pat  <= cfg_pattern;
      r_len  <= cfg_len;
      r_ovl  <= cfg_overlap;
      r_err  <= len_illegal(cfg_len);
      r_hist <= '0;
      r_fill <= '0;
    end else if (in_valid) begin
      if (w_match) begin
        r_cnt <= sat_inc_cnt(r_cnt);
        if (r_ovl) begin
          r_hist <= w_cand[PAT_W-1:0];
          r_fill <= sat_inc_fill(r_fill);
        end else begin
          // Non-overlapping: none of the matched bits may seed the next match.
          r_hist <= '0;
          r_fill <= '0;
        end
      end else begin
        r_hist <= w_cand[PAT_W-1:0];
        r_fill <= sat_inc_fill(r_fill);
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_prog.sv
module tb_seq_detect_prog;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;

  logic             clk;
  logic             rst;
  logic             in_seq;
  logic             in_valid;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             det_out;
  logic [7:0]       match_cnt;
  logic             cfg_err;
  logic             det2;
  logic [1:0]       cnt2;
  logic             err2;

  int n_checks;
  int n_errors;

  seq_detect_prog dut (
    .clk(clk), .rst(rst), .in_seq(in_seq), .in_valid(in_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .det_out(det_out), .match_cnt(match_cnt),
    .cfg_err(cfg_err)
  );

  seq_detect_prog #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_seq(in_seq), .in_valid(in_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .det_out(det2), .match_cnt(cnt2),
    .cfg_err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of input at the falling edge and sample det_out after settling.
  task automatic drive_bit(input logic b, input logic v, output logic d);
    @(negedge clk);
    in_seq   = b;
    in_valid = v;
    cfg_load = 1'b0;
    #1 d = det_out;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    cfg_load = 1'b0;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    cfg_load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load_cfg(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                          input logic ovl);
    @(negedge clk);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_load    = 1'b1;
    in_valid    = 1'b0;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b1;
    in_seq   = 1'b0;
    #1;
    n_checks++;
    if (det_out !== 1'b0) begin
      n_errors++; $display("FAIL reset_det got %b want 0", det_out);
    end
    n_checks++;
    if (match_cnt !== 8'd0) begin
      n_errors++; $display("FAIL reset_cnt got %0d want 0", match_cnt);
    end
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_errors++; $display("FAIL reset_err got %b want 0", cfg_err);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
  endtask

  task automatic test_default_stream();
    logic [9:0] stim;
    logic [9:0] expd;
    logic d;
    stim = 10'b1011010110;
    expd = 10'b0000100001;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive_bit(stim[9-i], 1'b1, d);
      n_checks++;
      if (d !== expd[9-i]) begin
        n_errors++; $display("FAIL default_det bit%0d got %b want %b", i+1, d, expd[9-i]);
      end
    end
    idle();
    n_checks++;
    if (match_cnt !== 8'd2) begin
      n_errors++; $display("FAIL default_cnt got %0d want 2", match_cnt);
    end
  endtask

  task automatic test_overlap(input logic ovl);
    logic [4:0] stim;
    logic [4:0] expd;
    logic [7:0] ecnt;
    logic d;
    stim = 5'b10101;
    expd = ovl ? 5'b00101 : 5'b00100;
    ecnt = ovl ? 8'd2 : 8'd1;
    apply_reset();
    load_cfg(8'b0000_0101, 4'd3, ovl);
    for (int i = 0; i < 5; i++) begin
      drive_bit(stim[4-i], 1'b1, d);
      n_checks++;
      if (d !== expd[4-i]) begin
        n_errors++; $display("FAIL ovl%0b_det bit%0d got %b want %b", ovl, i+1, d, expd[4-i]);
      end
    end
    idle();
    n_checks++;
    if (match_cnt !== ecnt) begin
      n_errors++; $display("FAIL ovl%0b_cnt got %0d want %0d", ovl, match_cnt, ecnt);
    end
  endtask

  task automatic test_stall();
    logic d;
    apply_reset();
    drive_bit(1'b1, 1'b1, d);
    drive_bit(1'b0, 1'b1, d);
    drive_bit(1'b1, 1'b1, d);
    for (int i = 0; i < 4; i++) begin
      drive_bit(1'b1, 1'b0, d);
      n_checks++;
      if (d !== 1'b0) begin
        n_errors++; $display("FAIL stall_det cyc%0d got %b want 0", i, d);
      end
    end
    drive_bit(1'b1, 1'b1, d);
    n_checks++;
    if (d !== 1'b0) begin
      n_errors++; $display("FAIL stall_bit4 got %b want 0", d);
    end
    drive_bit(1'b0, 1'b1, d);
    n_checks++;
    if (d !== 1'b1) begin
      n_errors++; $display("FAIL stall_final got %b want 1", d);
    end
    idle();
    n_checks++;
    if (match_cnt !== 8'd1) begin
      n_errors++; $display("FAIL stall_cnt got %0d want 1", match_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] stim;
    logic d;
    stim = 5'b10110;
    apply_reset();
    drive_bit(1'b1, 1'b1, d);
    drive_bit(1'b0, 1'b1, d);
    drive_bit(1'b1, 1'b1, d);
    drive_bit(1'b1, 1'b1, d);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b1;
    in_seq   = 1'b0;
    #1;
    n_checks++;
    if (det_out !== 1'b0) begin
      n_errors++; $display("FAIL midrst_det_in_reset got %b want 0", det_out);
    end
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    drive_bit(1'b0, 1'b1, d);
    n_checks++;
    if (d !== 1'b0) begin
      n_errors++; $display("FAIL midrst_after got %b want 0", d);
    end
    for (int i = 0; i < 5; i++) begin
      drive_bit(stim[4-i], 1'b1, d);
      n_checks++;
      if (d !== (i == 4)) begin
        n_errors++; $display("FAIL midrst_det bit%0d got %b want %b", i+1, d, (i == 4));
      end
    end
  endtask

  task automatic test_cfg_err();
    logic [4:0] stim;
    logic d;
    stim = 5'b10110;
    apply_reset();
    load_cfg(8'b0001_0110, 4'd0, 1'b0);
    #1;
    n_checks++;
    if (cfg_err !== 1'b1) begin
      n_errors++; $display("FAIL err_len0 got %b want 1", cfg_err);
    end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) begin
        drive_bit(stim[4-i], 1'b1, d);
        n_checks++;
        if (d !== 1'b0) begin
          n_errors++; $display("FAIL err_det r%0d bit%0d got %b want 0", r, i+1, d);
        end
      end
    end
    idle();
    n_checks++;
    if (match_cnt !== 8'd0) begin
      n_errors++; $display("FAIL err_cnt got %0d want 0", match_cnt);
    end
    load_cfg(8'b0001_0110, 4'd9, 1'b0);
    #1;
    n_checks++;
    if (cfg_err !== 1'b1) begin
      n_errors++; $display("FAIL err_len9 got %b want 1", cfg_err);
    end
    load_cfg(8'b0000_0001, 4'd2, 1'b0);
    #1;
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_errors++; $display("FAIL err_len2 got %b want 0", cfg_err);
    end
    load_cfg(8'b1000_0000, 4'd8, 1'b0);
    #1;
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_errors++; $display("FAIL err_len8 got %b want 0", cfg_err);
    end
  endtask

  task automatic test_load_collision();
    logic d;
    apply_reset();
    drive_bit(1'b1, 1'b1, d);
    drive_bit(1'b0, 1'b1, d);
    drive_bit(1'b1, 1'b1, d);
    drive_bit(1'b1, 1'b1, d);
    // The completing bit arrives together with a reload of the same pattern.
    @(negedge clk);
    cfg_pattern = 8'b0001_0110;
    cfg_len     = 4'd5;
    cfg_overlap = 1'b0;
    cfg_load    = 1'b1;
    in_valid    = 1'b1;
    in_seq      = 1'b0;
    #1;
    n_checks++;
    if (det_out !== 1'b0) begin
      n_errors++; $display("FAIL coll_det got %b want 0", det_out);
    end
    drive_bit(1'b0, 1'b1, d);
    n_checks++;
    if (d !== 1'b0) begin
      n_errors++; $display("FAIL coll_after got %b want 0", d);
    end
    idle();
    n_checks++;
    if (match_cnt !== 8'd0) begin
      n_errors++; $display("FAIL coll_cnt got %0d want 0", match_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [4:0] stim;
    logic [1:0] ecnt;
    logic d;
    stim = 5'b10110;
    apply_reset();
    for (int k = 1; k <= 5; k++) begin
      for (int i = 0; i < 5; i++) begin
        drive_bit(stim[4-i], 1'b1, d);
      end
      idle();
      ecnt = (k >= 3) ? 2'd3 : 2'(k);
      n_checks++;
      if (cnt2 !== ecnt) begin
        n_errors++; $display("FAIL sat_cnt2 k%0d got %0d want %0d", k, cnt2, ecnt);
      end
    end
    n_checks++;
    if (match_cnt !== 8'd5) begin
      n_errors++; $display("FAIL sat_cnt8 got %0d want 5", match_cnt);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b0;
    in_seq      = 1'b0;
    in_valid    = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    test_reset();
    test_default_stream();
    test_overlap(1'b1);
    test_overlap(1'b0);
    test_stall();
    test_reset_mid();
    test_cfg_err();
    test_load_collision();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_prog.md
SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

Interface
Parameters:
REQ-001 The block SHALL have parameter PAT_W, default 8, meaning the maximum pattern length in bits (legal range 2..32).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the match counter.
REQ-003 The block SHALL have parameter DEF_PAT, default 8'b0001_0110, meaning the pattern active out of reset.
REQ-004 The block SHALL have parameter DEF_LEN, default 5, meaning the pattern length active out of reset.
REQ-005 The block SHALL have parameter DEF_OVL, default 0, meaning the overlap mode active out of reset (0 = non-overlapping).
REQ-006 The block SHALL derive LEN_W = clog2(PAT_W+1).

Ports:
REQ-007 The block SHALL have port clk, input, width 1: the single clock, rising edge.
REQ-008 The block SHALL have port rst, input, width 1: asynchronous, active-low reset.
REQ-009 The block SHALL have port in_seq, input, width 1: serial data bit.
REQ-010 The block SHALL have port in_valid, input, width 1: in_seq is sampled this cycle.
REQ-011 The block SHALL have port cfg_load, input, width 1: one-cycle pulse that latches the cfg_* inputs.
REQ-012 The block SHALL have port cfg_pattern, input, width PAT_W: the pattern; bit [len-1] is received first and bit [0] last.
REQ-013 The block SHALL have port cfg_len, input, width LEN_W: the pattern length.
REQ-014 The block SHALL have port cfg_overlap, input, width 1: 1 = overlapping detection.
REQ-015 The block SHALL have port det_out, output, width 1: Mealy match indication.
REQ-016 The block SHALL have port match_cnt, output, width CNT_W: saturating count of matches.
REQ-017 The block SHALL have port cfg_err, output, width 1: the active configuration is illegal.

Function
REQ-018 The block SHALL hold the active config (pattern, len, overlap), a PAT_W-bit history shift register, and a fill counter (0..PAT_W).
REQ-019 On a cycle with in_valid=1 and cfg_load=0, the block SHALL compute cand = {history, in_seq}; the low len bits are compared.
REQ-020 The block SHALL assert det_out combinationally in the same cycle when in_valid=1, cfg_load=0, cfg_err=0, fill+1 >= len, and cand[len-1:0] == pattern[len-1:0]; det_out SHALL be 0 otherwise (zero latency, Mealy).
REQ-021 On every accepted bit, the block SHALL shift in_seq into history bit 0 at the clock edge.
REQ-022 On an accepted bit with no match, fill SHALL increment, saturating at PAT_W.
REQ-023 On a match with overlap=1, fill SHALL increment (saturating) and history SHALL keep the shifted value.
REQ-024 On a match with overlap=0, fill SHALL clear to 0 and history SHALL clear to 0, so that no bit of the match is reused.
REQ-025 With in_valid=0, history, fill and match_cnt SHALL hold and det_out SHALL be 0.
REQ-026 On each match, match_cnt SHALL increment, saturating at 2^CNT_W-1 without wrapping.
REQ-027 When cfg_load=1, the block SHALL latch the cfg_* inputs into the active config and clear history and fill; match_cnt SHALL be unchanged.
REQ-028 When cfg_load=1 coincides with in_valid=1, cfg_load SHALL win: the bit is discarded and det_out is 0.
REQ-029 cfg_err SHALL be 1 (registered, from the active config) when len < 2 or len > PAT_W.
REQ-030 While cfg_err=1, det_out SHALL never assert and match_cnt SHALL hold.

Reset
REQ-031 When rst=0, asynchronously: history=0, fill=0, match_cnt=0, active pattern=DEF_PAT, len=DEF_LEN, overlap=DEF_OVL, cfg_err derived from DEF_LEN.
REQ-032 det_out SHALL be 0 while rst=0.
REQ-033 The first bit accepted after rst deasserts SHALL be treated as bit 1 of a fresh stream.
REQ-034 Reset asserted mid-pattern SHALL discard all partial progress.

Verification
REQ-035 Defaults (10110, non-overlap), stream 1,0,1,1,0,1,0,1,1,0 -> det_out=1 on bits 5 and 10 only; match_cnt=2.
REQ-036 Load pattern 101, len 3, overlap=1; stream 1,0,1,0,1 -> det_out on bits 3 and 5; match_cnt=2.
REQ-037 Same stream with overlap=0 -> det_out on bit 3 only; match_cnt=1.
REQ-038 Defaults, stream 1,0,1 then in_valid=0 for 4 cycles, then 1,0 -> det_out=1 on the final bit only; det_out=0 during the stall.
REQ-039 Defaults, send 1,0,1,1, assert rst=0 for 1 cycle, then send 0 -> no det_out; then 1,0,1,1,0 -> det_out=1 on the 5th bit.
REQ-040 Load len=0 -> cfg_err=1 and no det_out on any stream; CNT_W=2 with 5 matches of a legal pattern -> match_cnt=3, then it holds.
